mips_mc_control: RTL and testbench
==================================

# mips_mc_control

Multi-cycle control unit for the MIPS datapath. A Moore state machine with memory-ready qualification steps each instruction through fetch, decode, execute, memory and writeback. It drives every datapath select and enable, including the PC-enable that the datapath currently derives by hand. It stalls on a shared-memory ready handshake, flags unsupported opcodes, and counts retired instructions for bench checking.

## Interface

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces IDLE immediately.
- opcode  in  6  inst[31:26] from the instruction register.
- zero  in  1  ALU zero flag; sampled in BRANCH only.
- mem_ready  in  1  memory access completes this cycle.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory.
- irwrite  out  1  load instruction register.
- memtoreg  out  1  writeback source: 0 = ALUOut, 1 = MDR.
- regdst  out  1  destination register: 0 = rt, 1 = rd.
- regwrite  out  1  register file write enable.
- alusrca  out  1  ALU A input: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B input: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- aluop  out  2  ALU op class: 00 = add, 01 = sub, 10 = decode funct.
- pcsource  out  2  next-PC select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- pc_en  out  1  PC load enable: pcwrite OR (pcwritecond AND zero).
- illegal  out  1  one-cycle pulse on unsupported opcode.
- state  out  4  current state encoding, for debug.
- instr_count  out  CNT_W  retired-instruction count.

## Operation

State encodings:
- IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12.
- Encodings 13–15 are unreachable. If entered, the FSM goes to FETCH the next cycle with all outputs 0.

Reset state IDLE:
- All outputs 0, instr_count=0.
- IDLE always goes to FETCH.

FETCH:
- Outputs: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00.
- irwrite = pc_en = mem_ready.
- Holds while mem_ready=0; goes to DECODE when mem_ready=1.

DECODE:
- Outputs: alusrca=0, alusrcb=11, aluop=00.
- Next state by opcode:
  - 000000 → EXEC
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JUMP
  - any other opcode → FETCH, with illegal=1 for that DECODE cycle.

lw / sw path:
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: memread=1, iord=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Goes to FETCH.
- MEMWR: memwrite=1, iord=1. Holds until mem_ready=1, then goes to FETCH.

R-type path:
- EXEC: alusrca=1, alusrcb=00, aluop=10. Goes to ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0. Goes to FETCH.

beq path:
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsource=01, pc_en=zero. Goes to FETCH.

addi path:
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Goes to ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0. Goes to FETCH.

j path:
- JUMP: pcsource=10, pc_en=1. Goes to FETCH.

Defaults and counter:
- Any output not listed for a state is 0.
- instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP.
- It does not increment on an illegal-opcode return or on the IDLE→FETCH transition.
- It wraps modulo 2^CNT_W.

## Timing

- Outputs are combinational from state, plus mem_ready (FETCH) and zero (BRANCH). There is no output register.
- Cycles per instruction with mem_ready held at 1:
  - j, beq: 3
  - R-type, addi: 4
  - sw: 4
  - lw: 5
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds 1 cycle. memread/memwrite stay asserted and address selects stay stable.
- The opcode input is sampled only in DECODE and MEMADR. The instruction register must hold it through MEMADR.
- reset going low mid-instruction:
  - state goes to IDLE and instr_count to 0 without waiting for a clock edge.
  - All outputs go to 0 in the same cycle; an in-flight memory request is abandoned.
- Reset release takes effect at the first rising edge with reset=1. That edge moves IDLE→FETCH.

## Test plan

- Reset: hold reset=0 for 3 cycles, then release → state=0 and all outputs 0 during reset; state=1 on the first edge after release.
- R-type: opcode 000000 (instruction 0x02002005), mem_ready=1 → states 1,2,7,8,1. In ALUWB, regwrite=1, regdst=1, aluop=10 during EXEC. instr_count=1.
- lw with stall: opcode 100011, mem_ready=0 for 2 cycles in MEMRD → MEMRD lasts 3 cycles with memread=1, iord=1. Then MEMWB with memtoreg=1. Total 7 cycles; instr_count increments once.
- beq: opcode 000100, run once with zero=1 and once with zero=0 → pc_en=1 then pc_en=0 in BRANCH, pcsource=01 both times. Each takes 3 cycles.
- Illegal: opcode 111111 → illegal=1 for exactly one DECODE cycle, then FETCH. instr_count unchanged.
- Mid-op reset: drive reset=0 during MEMWR with memwrite=1 → memwrite=0 and state=0 asynchronously, instr_count=0.

Source files
------------

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control unit: Moore FSM stepping each instruction through
// fetch/decode/execute/memory/writeback, with memory-ready stalls, an
// illegal-opcode pulse and a retired-instruction counter.
module mips_mc_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             memread,
  output logic             memwrite,
  output logic             iord,
  output logic             irwrite,
  output logic             memtoreg,
  output logic             regdst,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsource,
  output logic             pc_en,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t cur_state;
  state_t next_state;
  logic   retire;

  assign state = cur_state;

  // State register; reset returns to IDLE without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= S_IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  // Retired-instruction counter, bumped on every completing return to FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_count <= '0;
    end else if (retire) begin
      instr_count <= instr_count + 1'b1;
    end
  end

  // Next-state and Moore outputs (FETCH/BRANCH also qualify on mem_ready/zero).
  always_comb begin
    next_state = S_FETCH;
    retire     = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    pcsource   = 2'b00;
    pc_en      = 1'b0;
    illegal    = 1'b0;
    case (cur_state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        memread    = 1'b1;
        alusrcb    = 2'b01;
        irwrite    = mem_ready;
        pc_en      = mem_ready;
        next_state = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (opcode)
          OP_RTYPE:     next_state = S_EXEC;
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default: begin
            next_state = S_FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        memread    = 1'b1;
        iord       = 1'b1;
        next_state = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        memwrite   = 1'b1;
        iord       = 1'b1;
        retire     = mem_ready;
        next_state = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alusrca    = 1'b1;
        aluop      = 2'b10;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsource = 2'b01;
        pc_en    = zero;
        retire   = 1'b1;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_JUMP: begin
        pcsource = 2'b10;
        pc_en    = 1'b1;
        retire   = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: the stimulus process queues the
// expected per-cycle response, a negedge monitor pops and compares it.
module tb_mips_mc_control;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        memread, memwrite, iord, irwrite, memtoreg, regdst, regwrite;
  logic        alusrca, pc_en, illegal;
  logic [1:0]  alusrcb, aluop, pcsource;
  logic [3:0]  state;
  logic [31:0] instr_count;

  mips_mc_control #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource), .pc_en(pc_en),
    .illegal(illegal), .state(state), .instr_count(instr_count)
  );

  // Output vector bit order:
  // memread memwrite iord irwrite memtoreg regdst regwrite alusrca
  // alusrcb[1:0] aluop[1:0] pcsource[1:0] pc_en illegal
  localparam logic [15:0] O_NONE   = 16'h0000;
  localparam logic [15:0] O_FET1   = 16'h9042;
  localparam logic [15:0] O_FET0   = 16'h8040;
  localparam logic [15:0] O_DEC    = 16'h00C0;
  localparam logic [15:0] O_DECILL = 16'h00C1;
  localparam logic [15:0] O_MEMADR = 16'h0180;
  localparam logic [15:0] O_MEMRD  = 16'hA000;
  localparam logic [15:0] O_MEMWB  = 16'h0A00;
  localparam logic [15:0] O_MEMWR  = 16'h6000;
  localparam logic [15:0] O_EXEC   = 16'h0120;
  localparam logic [15:0] O_ALUWB  = 16'h0600;
  localparam logic [15:0] O_BR1    = 16'h0116;
  localparam logic [15:0] O_BR0    = 16'h0114;
  localparam logic [15:0] O_ADDIEX = 16'h0180;
  localparam logic [15:0] O_ADDIWB = 16'h0200;
  localparam logic [15:0] O_JUMP   = 16'h000A;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] outs;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare the DUT against the queued expectation each cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e   = exp_q.pop_front();
      act = {memread, memwrite, iord, irwrite, memtoreg, regdst, regwrite, alusrca,
             alusrcb, aluop, pcsource, pc_en, illegal};
      checks++;
      if (state !== e.st) begin
        errors++;
        $display("FAIL state @%0t: got %0d want %0d", $time, state, e.st);
      end
      checks++;
      if (act !== e.outs) begin
        errors++;
        $display("FAIL outs @%0t (state %0d): got %h want %h", $time, state, act, e.outs);
      end
      checks++;
      if (instr_count !== e.cnt) begin
        errors++;
        $display("FAIL instr_count @%0t: got %0d want %0d", $time, instr_count, e.cnt);
      end
    end
  end

  // Drive one cycle of inputs, queue its expected response, advance a cycle.
  task automatic cyc(input logic rst, input logic [5:0] op, input logic mr,
                     input logic z, input logic [3:0] st, input logic [15:0] o,
                     input logic [31:0] c);
    exp_t e;
    reset     = rst;
    opcode    = op;
    mem_ready = mr;
    zero      = z;
    e.st = st; e.outs = o; e.cnt = c;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    // Reset held three cycles, then released (still IDLE until next edge).
    for (int i = 0; i < 3; i++) cyc(0, 6'h00, 1, 0, 4'd0, O_NONE, 0);
    cyc(1, 6'h00, 1, 0, 4'd0, O_NONE, 0);
    // R-type (0x02002005)
    cyc(1, 6'b000000, 1, 0, 4'd1, O_FET1, 0);
    cyc(1, 6'b000000, 1, 0, 4'd2, O_DEC, 0);
    cyc(1, 6'b000000, 1, 0, 4'd7, O_EXEC, 0);
    cyc(1, 6'b000000, 1, 0, 4'd8, O_ALUWB, 0);
    // lw with two stall cycles in MEMRD
    cyc(1, 6'b100011, 1, 0, 4'd1, O_FET1, 1);
    cyc(1, 6'b100011, 1, 0, 4'd2, O_DEC, 1);
    cyc(1, 6'b100011, 1, 0, 4'd3, O_MEMADR, 1);
    cyc(1, 6'b100011, 0, 0, 4'd4, O_MEMRD, 1);
    cyc(1, 6'b100011, 0, 0, 4'd4, O_MEMRD, 1);
    cyc(1, 6'b100011, 1, 0, 4'd4, O_MEMRD, 1);
    cyc(1, 6'b100011, 1, 0, 4'd5, O_MEMWB, 1);
    // beq taken, then not taken
    cyc(1, 6'b000100, 1, 1, 4'd1, O_FET1, 2);
    cyc(1, 6'b000100, 1, 1, 4'd2, O_DEC, 2);
    cyc(1, 6'b000100, 1, 1, 4'd9, O_BR1, 2);
    cyc(1, 6'b000100, 1, 0, 4'd1, O_FET1, 3);
    cyc(1, 6'b000100, 1, 0, 4'd2, O_DEC, 3);
    cyc(1, 6'b000100, 1, 0, 4'd9, O_BR0, 3);
    // illegal opcode, with a fetch stall first
    cyc(1, 6'b111111, 0, 0, 4'd1, O_FET0, 4);
    cyc(1, 6'b111111, 1, 0, 4'd1, O_FET1, 4);
    cyc(1, 6'b111111, 1, 0, 4'd2, O_DECILL, 4);
    // addi
    cyc(1, 6'b001000, 1, 0, 4'd1, O_FET1, 4);
    cyc(1, 6'b001000, 1, 0, 4'd2, O_DEC, 4);
    cyc(1, 6'b001000, 1, 0, 4'd10, O_ADDIEX, 4);
    cyc(1, 6'b001000, 1, 0, 4'd11, O_ADDIWB, 4);
    // j
    cyc(1, 6'b000010, 1, 0, 4'd1, O_FET1, 5);
    cyc(1, 6'b000010, 1, 0, 4'd2, O_DEC, 5);
    cyc(1, 6'b000010, 1, 0, 4'd12, O_JUMP, 5);
    // sw, no stall
    cyc(1, 6'b101011, 1, 0, 4'd1, O_FET1, 6);
    cyc(1, 6'b101011, 1, 0, 4'd2, O_DEC, 6);
    cyc(1, 6'b101011, 1, 0, 4'd3, O_MEMADR, 6);
    cyc(1, 6'b101011, 1, 0, 4'd6, O_MEMWR, 6);
    // sw stalled, then reset asserted mid-cycle while in MEMWR
    cyc(1, 6'b101011, 1, 0, 4'd1, O_FET1, 7);
    cyc(1, 6'b101011, 1, 0, 4'd2, O_DEC, 7);
    cyc(1, 6'b101011, 1, 0, 4'd3, O_MEMADR, 7);
    cyc(1, 6'b101011, 0, 0, 4'd6, O_MEMWR, 7);
    cyc(0, 6'b101011, 0, 0, 4'd0, O_NONE, 0);
    // Release and resume fetching
    cyc(1, 6'b000000, 1, 0, 4'd0, O_NONE, 0);
    cyc(1, 6'b000000, 1, 0, 4'd1, O_FET1, 0);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    done = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #50000;
    if (!done) begin
      $display("FAIL timeout: bench did not finish within 50000 time units");
      $fatal(1, "timeout");
    end
  end

endmodule
